// File: rtl/gemm_pkg.sv
// Shared types and elaboration helpers for the GEMM array sequencer.
package gemm_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_e;

  function automatic int chunks_per_pass(input int channel, input int array_n);
    return channel / array_n;
  endfunction

  function automatic int passes_per_job(input int out_ch, input int array_m);
    return out_ch / array_m;
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gemm_valid_pipe.sv
// Fixed-depth delay line aligning accumulator strobes with PE array output.
module gemm_valid_pipe #(
  parameter int DEPTH = 3,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] out_o
);

  logic [DEPTH-1:0][W-1:0] vld_pipe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= in_i;
      for (int i = 1; i < DEPTH; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  assign out_o = vld_pipe_q[DEPTH-1];

endmodule

// File: rtl/gemm_ctrl.sv
// GEMM job sequencer: chunked buffer reads, accumulator timing and
// per-pass result handoff to the output buffer.
module gemm_ctrl
  import gemm_pkg::*;
#(
  parameter int ARRAY_N    = 16,
  parameter int ARRAY_M    = 2,
  parameter int CHANNEL    = 96,
  parameter int OUT_CH     = 8,
  parameter int PE_LATENCY = 2,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  inp_rd_en,
  output logic [ADDR_WIDTH-1:0] inp_rd_addr,
  output logic                  wgt_rd_en,
  output logic [ADDR_WIDTH-1:0] wgt_rd_addr,
  output logic                  acc_en,
  output logic                  acc_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr
);

  localparam int K  = chunks_per_pass(CHANNEL, ARRAY_N);
  localparam int P  = passes_per_job(OUT_CH, ARRAY_M);
  localparam int KW = cnt_w(K);
  localparam int PW = cnt_w(P);
  localparam int DW = cnt_w(PE_LATENCY + 1);

  if ((CHANNEL % ARRAY_N) != 0 || (OUT_CH % ARRAY_M) != 0) begin : g_bad_param
    $fatal(1, "gemm_ctrl: CHANNEL/OUT_CH must be multiples of ARRAY_N/ARRAY_M");
  end

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [PW-1:0]   p_q, p_d;
  logic [DW-1:0]   drn_q, drn_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      p_q     <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      p_q     <= p_d;
      drn_q   <= drn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    p_d     = p_q;
    drn_d   = drn_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        k_d     = '0;
        p_d     = '0;
      end
      FETCH: begin
        if (k_q == KW'(K - 1)) begin
          state_d = DRAIN;
          drn_d   = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      // PE_LATENCY+1 idle cycles let the last chunk reach the accumulator.
      DRAIN: begin
        if (drn_q == DW'(PE_LATENCY)) state_d = WRITE;
        else                          drn_d   = drn_q + 1'b1;
      end
      WRITE: if (out_ready) begin
        if (p_q == PW'(P - 1)) begin
          state_d = DONE;
        end else begin
          state_d = FETCH;
          p_d     = p_q + 1'b1;
          k_d     = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic       rd_en;
  logic [1:0] acc_in, acc_out;

  assign rd_en       = (state_q == FETCH);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign inp_rd_en   = rd_en;
  assign wgt_rd_en   = rd_en;
  assign inp_rd_addr = rd_en ? ADDR_WIDTH'(k_q) : '0;
  assign wgt_rd_addr = rd_en ? (ADDR_WIDTH'(p_q) * ADDR_WIDTH'(K) + ADDR_WIDTH'(k_q)) : '0;
  assign out_valid   = (state_q == WRITE);
  assign out_addr    = out_valid ? ADDR_WIDTH'(p_q) : '0;

  // One cycle of buffer read latency plus the PE pipeline depth.
  assign acc_in = {rd_en, rd_en & (k_q == '0)};

  gemm_valid_pipe #(
    .DEPTH (1 + PE_LATENCY),
    .W     (2)
  ) u_acc_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .in_i  (acc_in),
    .out_o (acc_out)
  );

  assign acc_en  = acc_out[1];
  assign acc_clr = acc_out[0];

endmodule

// File: tb/tb_gemm_ctrl.sv
// Scoreboard bench for gemm_ctrl: job-level reference schedule vs. observed strobes.
module tb_gemm_ctrl;

  localparam int K  = 6;
  localparam int P  = 4;
  localparam int PL = 2;

  typedef struct {int t; int a; int b;} ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       out_ready = 1'b1;
  logic       busy, done, inp_rd_en, wgt_rd_en, acc_en, acc_clr, out_valid;
  logic [7:0] inp_rd_addr, wgt_rd_addr, out_addr;

  logic       start2 = 1'b0;
  logic       out_ready2 = 1'b1;
  logic       busy2, done2, inp_rd_en2, wgt_rd_en2, acc_en2, acc_clr2, out_valid2;
  logic [7:0] inp_rd_addr2, wgt_rd_addr2, out_addr2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int base    = 0;
  int hs_cnt  = 0;
  int last_done_rel = -1;
  int stall_a[P];
  int wcnt = 0;

  ev_t q_rd[$];
  ev_t q_acc[$];
  ev_t q_wr[$];
  ev_t q_done[$];

  gemm_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .inp_rd_en(inp_rd_en), .inp_rd_addr(inp_rd_addr),
    .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr),
    .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr)
  );

  gemm_ctrl #(
    .ARRAY_N(16), .ARRAY_M(2), .CHANNEL(32), .OUT_CH(2), .PE_LATENCY(3), .ADDR_WIDTH(8)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .inp_rd_en(inp_rd_en2), .inp_rd_addr(inp_rd_addr2),
    .wgt_rd_en(wgt_rd_en2), .wgt_rd_addr(wgt_rd_addr2),
    .acc_en(acc_en2), .acc_clr(acc_clr2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_addr(out_addr2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int all_outs();
    return int'({busy, done, inp_rd_en, inp_rd_addr, wgt_rd_en, wgt_rd_addr,
                 acc_en, acc_clr, out_valid, out_addr});
  endfunction

  // Output buffer model: holds ready low for stall_a[pass] cycles of each WRITE.
  always @(posedge clk) begin
    #1;
    if (!out_valid) begin
      wcnt = 0;
      out_ready = 1'b1;
    end else if (out_addr < 8'(P) && wcnt < stall_a[out_addr]) begin
      out_ready = 1'b0;
      wcnt++;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: every strobe the DUT shows must match the head of its queue.
  always @(negedge clk) begin : mon
    int  rel;
    ev_t e;
    if (rst_n) begin
      rel = cyc - base;
      chk("wgt_rd_en_tracks_inp", int'(wgt_rd_en), int'(inp_rd_en));
      if (inp_rd_en) begin
        if (q_rd.size() == 0) chk("unexpected_read", int'(inp_rd_en), 0);
        else begin
          e = q_rd.pop_front();
          chk("rd_cycle", rel, e.t);
          chk("inp_rd_addr", int'(inp_rd_addr), e.a);
          chk("wgt_rd_addr", int'(wgt_rd_addr), e.b);
        end
      end
      if (acc_en) begin
        if (q_acc.size() == 0) chk("unexpected_acc_en", int'(acc_en), 0);
        else begin
          e = q_acc.pop_front();
          chk("acc_en_cycle", rel, e.t);
          chk("acc_clr", int'(acc_clr), e.a);
        end
      end else if (acc_clr) begin
        chk("acc_clr_without_en", int'(acc_clr), 0);
      end
      if (out_valid && !out_ready && q_wr.size() != 0)
        chk("out_addr_stall_hold", int'(out_addr), q_wr[0].a);
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (q_wr.size() == 0) chk("unexpected_write", int'(out_valid), 0);
        else begin
          e = q_wr.pop_front();
          chk("write_cycle", rel, e.t);
          chk("out_addr", int'(out_addr), e.a);
        end
      end
      if (done) begin
        last_done_rel = rel;
        if (q_done.size() == 0) chk("unexpected_done", int'(done), 0);
        else begin
          e = q_done.pop_front();
          chk("done_cycle", rel, e.t);
        end
      end
    end
  end

  // Reference schedule for one job, cycles relative to c1 = first cycle after start.
  task automatic push_model(output int done_rel);
    int s, w;
    s = 1;
    for (int p = 0; p < P; p++) begin
      for (int k = 0; k < K; k++) begin
        q_rd.push_back('{s + k, k, p * K + k});
        q_acc.push_back('{s + k + 1 + PL, (k == 0) ? 1 : 0, 0});
      end
      w = s + K + PL + 1 + stall_a[p];
      q_wr.push_back('{w, p, 0});
      s = w + 1;
    end
    q_done.push_back('{s, 0, 0});
    done_rel = s;
  endtask

  task automatic flush();
    q_rd.delete(); q_acc.delete(); q_wr.delete(); q_done.delete();
  endtask

  task automatic run_job(input bit inj, input int rst_at);
    int dr, hs0;
    push_model(dr);
    hs0 = hs_cnt;
    @(negedge clk); base = cyc; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 2; i <= dr + 1; i++) begin
      @(negedge clk);
      start = (inj && (i == 5 || i == 20)) ? 1'b1 : 1'b0;
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        #1 chk("outputs_zero_in_reset", all_outs(), 0);
        flush();
        @(negedge clk); @(negedge clk);
        chk("outputs_zero_held_reset", all_outs(), 0);
        rst_n = 1'b1;
        return;
      end
    end
    start = 1'b0;
    chk("idle_after_done", all_outs(), 0);
    chk("pending_events", q_rd.size() + q_acc.size() + q_wr.size() + q_done.size(), 0);
    chk("handshakes_per_job", hs_cnt - hs0, P);
    flush();
  endtask

  task automatic run_small();
    int b2, wr, dn, rds, accs, clr_t, last_wgt;
    wr = -1; dn = -1; rds = 0; accs = 0; clr_t = -1; last_wgt = -1;
    @(negedge clk); b2 = cyc; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (i > 1) @(negedge clk);
      if (out_valid2 && wr < 0) wr = cyc - b2;
      if (done2) dn = cyc - b2;
      if (inp_rd_en2) begin rds++; last_wgt = int'(wgt_rd_addr2); end
      if (acc_en2) accs++;
      if (acc_en2 && acc_clr2) clr_t = cyc - b2;
    end
    chk("small_write_cycle", wr, 7);
    chk("small_done_cycle", dn, 8);
    chk("small_reads", rds, 2);
    chk("small_last_wgt_addr", last_wgt, 1);
    chk("small_acc_en_count", accs, 2);
    chk("small_acc_clr_cycle", clr_t, 5);
    chk("small_idle_busy", int'(busy2), 0);
  endtask

  initial begin
    for (int p = 0; p < P; p++) stall_a[p] = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    chk("reset_outputs_small", int'({busy2, done2, inp_rd_en2, wgt_rd_en2, acc_en2,
                                     acc_clr2, out_valid2}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outputs", all_outs(), 0);

    run_job(1'b0, 0);
    chk("done_at_c41", last_done_rel, 41);

    stall_a[1] = 5;
    run_job(1'b0, 0);
    chk("done_at_c46_with_stall", last_done_rel, 46);
    stall_a[1] = 0;

    run_job(1'b1, 0);
    chk("done_with_ignored_starts", last_done_rel, 41);

    run_job(1'b0, 15);
    repeat (2) @(negedge clk);
    run_job(1'b0, 0);
    chk("done_after_reset_rerun", last_done_rel, 41);

    for (int j = 0; j < 4; j++) begin
      for (int p = 0; p < P; p++) stall_a[p] = int'($urandom_range(0, 4));
      run_job(1'b0, 0);
    end
    for (int p = 0; p < P; p++) stall_a[p] = 0;

    repeat (10) @(negedge clk);
    chk("no_activity_when_idle", all_outs(), 0);

    run_small();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
